// File: rtl/lif_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron array: FSM encoding,
// default parameter values and width helpers for the saturating accumulator.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } lif_fsm_e;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_N_CH         = 4;
    localparam int DEF_LEAK_SHIFT   = 1;
    localparam int DEF_REFRAC_STEPS = 2;

    // One guard bit is enough: s - (s >> k) + c never exceeds 2 * (2^WIDTH - 1).
    localparam int SUM_GUARD_BITS = 1;

    function automatic int cnt_width(input int steps);
        return (steps < 1) ? 1 : $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/lif_core.sv
// Combinational single-neuron update: leak, integrate, saturate, fire and skip detect.
// Refractory counting is present only when LIF_REFRACTORY_EN is defined.
module lif_core
    import lif_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
    parameter int REFRAC_STEPS = DEF_REFRAC_STEPS,
    parameter int CNT_W        = cnt_width(DEF_REFRAC_STEPS)
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] threshold,
`ifdef LIF_REFRACTORY_EN
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
`endif
    output logic [WIDTH-1:0] s_next,
    output logic             spike,
    output logic             skip
);

    localparam int SUM_W = WIDTH + SUM_GUARD_BITS;

    function automatic logic [WIDTH-1:0] saturate(input logic [SUM_W-1:0] v);
        return (v[SUM_W-1:WIDTH] != '0) ? {WIDTH{1'b1}} : v[WIDTH-1:0];
    endfunction

    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] n;

    always_comb begin
        sum    = {1'b0, s} - {1'b0, (s >> LEAK_SHIFT)} + {1'b0, c};
        n      = saturate(sum);
        s_next = n;
        spike  = 1'b0;
`ifdef LIF_REFRACTORY_EN
        cnt_next = '0;
        skip     = (c == '0) && (s == '0) && (cnt == '0);
        // A refractory neuron is held at rest and ignores its input entirely.
        if (cnt != '0) begin
            s_next   = '0;
            cnt_next = cnt - CNT_W'(1);
        end else if (n >= threshold) begin
            s_next   = '0;
            spike    = 1'b1;
            cnt_next = CNT_W'(REFRAC_STEPS);
        end
`else
        skip = (c == '0) && (s == '0);
        if (n >= threshold) begin
            s_next = '0;
            spike  = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: one shared lif_core scans N_CH channels per timestep.
// Define LIF_REFRACTORY_EN to add per-channel refractory counters.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int N_CH         = DEF_N_CH,
    parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
    parameter int REFRAC_STEPS = DEF_REFRAC_STEPS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_CH*WIDTH-1:0]        current,
    input  logic [WIDTH-1:0]             threshold,
    output logic                         out_valid,
    output logic [N_CH-1:0]              spike,
    output logic [N_CH*WIDTH-1:0]        state,
    output logic [$clog2(N_CH+1)-1:0]    active_count
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AC_W  = $clog2(N_CH + 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] SCAN = ST_SCAN;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]            fsm;
    logic [IDX_W-1:0]      idx;
    logic [N_CH*WIDTH-1:0] cur_q;
    logic [WIDTH-1:0]      thr_q;
    logic [N_CH*WIDTH-1:0] mem_q;
    logic [N_CH-1:0]       spike_q;
    logic [AC_W-1:0]       act_work;
    logic [AC_W-1:0]       act_q;

    logic [WIDTH-1:0]      s_next;
    logic                  spike_c;
    logic                  skip;
    logic                  last_ch;

    assign last_ch = (idx == IDX_W'(N_CH - 1));

`ifdef LIF_REFRACTORY_EN
    localparam int CNT_W = cnt_width(REFRAC_STEPS);

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_next;

    lif_core #(
        .WIDTH        (WIDTH),
        .LEAK_SHIFT   (LEAK_SHIFT),
        .REFRAC_STEPS (REFRAC_STEPS),
        .CNT_W        (CNT_W)
    ) u_core (
        .s         (mem_q[idx*WIDTH +: WIDTH]),
        .c         (cur_q[idx*WIDTH +: WIDTH]),
        .threshold (thr_q),
        .cnt       (cnt_q[idx]),
        .cnt_next  (cnt_next),
        .s_next    (s_next),
        .spike     (spike_c),
        .skip      (skip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else if (fsm == SCAN && !skip) begin
            cnt_q[idx] <= cnt_next;
        end
    end
`else
    lif_core #(
        .WIDTH        (WIDTH),
        .LEAK_SHIFT   (LEAK_SHIFT),
        .REFRAC_STEPS (REFRAC_STEPS)
    ) u_core (
        .s         (mem_q[idx*WIDTH +: WIDTH]),
        .c         (cur_q[idx*WIDTH +: WIDTH]),
        .threshold (thr_q),
        .s_next    (s_next),
        .spike     (spike_c),
        .skip      (skip)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            idx      <= '0;
            cur_q    <= '0;
            thr_q    <= '0;
            mem_q    <= '0;
            spike_q  <= '0;
            act_work <= '0;
            act_q    <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        cur_q    <= current;
                        thr_q    <= threshold;
                        spike_q  <= '0;
                        idx      <= '0;
                        act_work <= '0;
                        fsm      <= SCAN;
                    end
                end
                SCAN: begin
                    // Skipped channels leave every register untouched.
                    if (!skip) begin
                        mem_q[idx*WIDTH +: WIDTH] <= s_next;
                        spike_q[idx]              <= spike_c;
                        act_work                  <= act_work + AC_W'(1);
                    end
                    if (last_ch) begin
                        act_q <= skip ? act_work : act_work + AC_W'(1);
                        fsm   <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE:    fsm <= IDLE;
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready     = (fsm == IDLE);
    assign out_valid    = (fsm == DONE);
    assign spike        = spike_q;
    assign state        = mem_q;
    assign active_count = act_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios plus randomized timesteps
// against an arithmetic reference model; adapts to LIF_REFRACTORY_EN.
module tb_lif_neuron_array;

    localparam int WIDTH = 8;
    localparam int N_CH  = 4;
    localparam int LS    = 1;
`ifdef LIF_REFRACTORY_EN
    localparam int REFRAC = 2;
`else
    localparam int REFRAC = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N_CH*WIDTH-1:0] current = '0;
    logic [WIDTH-1:0]      threshold = '0;
    logic                  out_valid;
    logic [N_CH-1:0]       spike;
    logic [N_CH*WIDTH-1:0] state;
    logic [2:0]            active_count;

    lif_neuron_array #(
        .WIDTH        (WIDTH),
        .N_CH         (N_CH),
        .LEAK_SHIFT   (LS),
        .REFRAC_STEPS (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .current      (current),
        .threshold    (threshold),
        .out_valid    (out_valid),
        .spike        (spike),
        .state        (state),
        .active_count (active_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int m_mem [N_CH];
    int m_ref [N_CH];
    int m_spk [N_CH];
    int m_act;
    int cur_v [N_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_mem[i] = 0;
            m_ref[i] = 0;
            m_spk[i] = 0;
        end
        m_act = 0;
    endfunction

    // Neuron behaviour from first principles: leak by division, integrate, clamp, fire.
    function automatic void model_step(input int thr);
        int n;
        m_act = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_spk[i] = 0;
            if (m_ref[i] > 0) begin
                m_mem[i] = 0;
                m_ref[i] = m_ref[i] - 1;
                m_act++;
            end else if (!(cur_v[i] == 0 && m_mem[i] == 0)) begin
                n = m_mem[i] - m_mem[i] / (2 ** LS) + cur_v[i];
                if (n > 255) n = 255;
                if (n >= thr) begin
                    m_spk[i] = 1;
                    m_mem[i] = 0;
                    m_ref[i] = REFRAC;
                end else begin
                    m_mem[i] = n;
                end
                m_act++;
            end
        end
    endfunction

    task automatic do_step(input int c0, input int c1, input int c2, input int c3, input int thr);
        int edges;
        logic [N_CH-1:0] exp_spk;
        cur_v = '{c0, c1, c2, c3};
        current   = {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
        threshold = thr[7:0];
        in_valid  = 1'b1;
        edges = 0;
        while (!in_ready && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check("ready_idle", in_ready, 1);
        @(posedge clk); #1;
        // Garbage held on the inputs during the scan must be ignored.
        current   = $urandom;
        threshold = $urandom;
        check("ready_scan", in_ready, 0);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        model_step(thr);
        check("latency", edges + 1, N_CH + 1);
        for (int i = 0; i < N_CH; i++) exp_spk[i] = (m_spk[i] != 0);
        check("spike", spike, exp_spk);
        for (int i = 0; i < N_CH; i++)
            check($sformatf("state%0d", i), state[i*WIDTH +: WIDTH], m_mem[i]);
        check("active_count", active_count, m_act);
        @(posedge clk); #1;
        check("pulse_end", out_valid, 0);
        check("ready_after", in_ready, 1);
    endtask

    function automatic int rnd_cur();
        return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 255));
    endfunction

    initial begin
        int ov_count;
        int exp_ref [3];
        int t0, t1, t2, t3;

        model_reset();

        // Reset state and quiet idle period
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_state", state, 0);
        check("rst_spike", spike, 0);
        check("rst_active", active_count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        ov_count = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) ov_count++;
        end
        check("idle_no_out_valid", ov_count, 0);

        // Sparsity
        do_step(0, 0, 0, 0, 200);
        check("sparse_act0", active_count, 0);
        check("sparse_spk0", spike, 0);
        do_step(0, 0, 1, 0, 200);
        check("sparse_act1", active_count, 1);
        check("sparse_state2", state[2*WIDTH +: WIDTH], 1);

        // Integrate and fire on channel 0
        do_step(120, 0, 0, 0, 200);
        check("if_step1", state[7:0], 120);
        do_step(120, 0, 0, 0, 200);
        check("if_step2", state[7:0], 180);
        do_step(120, 0, 0, 0, 200);
        check("if_step3_spike", spike[0], 1);
        check("if_step3_state", state[7:0], 0);

        // Behaviour after the spike
`ifdef LIF_REFRACTORY_EN
        exp_ref = '{0, 0, 120};
`else
        exp_ref = '{120, 180, 0};
`endif
        for (int k = 0; k < 3; k++) begin
            do_step(120, 0, 0, 0, 200);
            check($sformatf("post_spike_state%0d", k), state[7:0], exp_ref[k]);
        end

        // Saturation on channel 1
        do_step(0, 200, 0, 0, 255);
        check("sat_pre", state[15:8], 200);
        do_step(0, 255, 0, 0, 255);
        check("sat_spike", spike[1], 1);
        check("sat_state", state[15:8], 0);

        // Zero threshold: every evaluated, non-refractory channel fires
        do_step(5, 0, 0, 9, 0);
        check("thr0_spike3", spike[3], 1);

        // Randomized timesteps
        repeat (20) begin
            t0 = rnd_cur(); t1 = rnd_cur(); t2 = rnd_cur(); t3 = rnd_cur();
            do_step(t0, t1, t2, t3, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)));
        end

        // Reset asserted mid-scan
        current   = {8'd50, 8'd60, 8'd70, 8'd80};
        threshold = 8'd250;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        ov_count = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) ov_count++;
        end
        rst_n = 1'b1;
        #1;
        model_reset();
        check("midrst_state", state, 0);
        check("midrst_spike", spike, 0);
        check("midrst_active", active_count, 0);
        check("midrst_ready", in_ready, 1);
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) ov_count++;
        end
        check("midrst_no_out_valid", ov_count, 0);

        // Continued operation from the cleared state
        do_step(100, 0, 0, 30, 150);
        check("after_rst_state0", state[7:0], 100);
        repeat (5) begin
            t0 = rnd_cur(); t1 = rnd_cur(); t2 = rnd_cur(); t3 = rnd_cur();
            do_step(t0, t1, t2, t3, int'($urandom_range(1, 255)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
